// File: rtl/sram_req_arbiter_if.sv
// sram-like request/response bundle shared by the inst, data and bus sides.
// The requester drives master; the responder drives slave.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Merges inst and data sram-like masters into one tagged request stream.
// An in-order source FIFO routes each completion back to its master.
module sram_req_arbiter #(
    parameter int OUTST_DEPTH  = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(OUTST_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_req_arbiter_if.slave    inst_sram,
    sram_req_arbiter_if.slave    data_sram,
    sram_req_arbiter_if.master   bus,
    output logic                 bus_src,
    output logic [CNT_W-1:0]     outst_cnt
);

    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTST_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    typedef enum logic {
        S_OPEN = 1'b0,
        S_LOCK = 1'b1
    } lock_e;

    lock_e              r_state;
    lock_e              w_state_nxt;
    logic               r_lock_src;
    logic               w_lock_src_nxt;

    logic               r_fifo [OUTST_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [STV_W-1:0]   r_starve;

    logic               w_grant;
    logic               w_sel_req;
    logic               w_full;
    logic               w_bus_req;
    logic               w_accept;
    logic               w_pop;
    logic               w_head;

    assign w_sel_req = w_grant ? data_sram.req : inst_sram.req;
    assign w_full    = (r_cnt == DEPTH_C);
    // A locked request was already admitted, so it never re-checks full.
    assign w_bus_req = w_sel_req && ((r_state == S_LOCK) || !w_full);
    assign w_accept  = w_bus_req && bus.addr_ok;
    assign w_pop     = bus.data_ok && (r_cnt != '0);
    assign w_head    = r_fifo[r_rptr];

    // Lock state register: holds the source of a stalled bus request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_OPEN;
            r_lock_src <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_src <= w_lock_src_nxt;
        end
    end

    // Lock next state: lock on a stall, release on accept.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_src_nxt = r_lock_src;
        if (w_bus_req && !bus.addr_ok) begin
            w_state_nxt    = S_LOCK;
            w_lock_src_nxt = w_grant;
        end else if (w_accept) begin
            w_state_nxt    = S_OPEN;
        end
    end

    // Grant: locked source, else data-priority unless inst is starved.
    always_comb begin
        w_grant = 1'b0;
        if (r_state == S_LOCK) begin
            w_grant = r_lock_src;
        end else if (inst_sram.req && data_sram.req) begin
            w_grant = (r_starve != LIMIT_C);
        end else begin
            w_grant = data_sram.req;
        end
    end

    // Output mux: bus fields from the granted master, responses by source.
    always_comb begin
        bus.req           = w_bus_req;
        bus.wr            = w_grant ? data_sram.wr    : inst_sram.wr;
        bus.size          = w_grant ? data_sram.size  : inst_sram.size;
        bus.wstrb         = w_grant ? data_sram.wstrb : inst_sram.wstrb;
        bus.addr          = w_grant ? data_sram.addr  : inst_sram.addr;
        bus.wdata         = w_grant ? data_sram.wdata : inst_sram.wdata;
        bus_src           = w_grant;
        inst_sram.addr_ok = w_accept && !w_grant;
        data_sram.addr_ok = w_accept && w_grant;
        inst_sram.data_ok = w_pop && !w_head;
        data_sram.data_ok = w_pop && w_head;
        inst_sram.rdata   = '0;
        data_sram.rdata   = '0;
        if (w_pop && !w_head) begin
            inst_sram.rdata = bus.rdata;
        end
        if (w_pop && w_head) begin
            data_sram.rdata = bus.rdata;
        end
        outst_cnt         = r_cnt;
    end

    // Source FIFO: push on accept, pop on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < OUTST_DEPTH; i++) begin
                r_fifo[i] <= 1'b0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wptr] <= w_grant;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Starvation counter: data wins that overtake a waiting inst request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (!inst_sram.req) begin
            r_starve <= '0;
        end else if (w_accept) begin
            if (!w_grant) begin
                r_starve <= '0;
            end else if (r_starve != LIMIT_C) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

endmodule
